fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Pipelined IEEE-754-style floating-point adder/subtractor, parametrised in exponent and mantissa width.
//  Adds round-to-nearest-even, valid/ready backpressure, a subtract mode and status flags.
//  Sits in the convolution core's MAC accumulation path: multiplier products in, running partial sums out.
// PARAMETERS
//  EXP_W    8   exponent field width; bias = 2^(EXP_W-1)-1
//  MAN_W    23  stored fraction width; implicit leading 1
//  W        1+EXP_W+MAN_W  operand/result width (derived localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-low
//  OperandA   in   W      operand A {sign, exp, frac}
//  OperandB   in   W      operand B
//  sub        in   1      1: compute A - B (B sign inverted at capture)
//  in_valid   in   1      operands valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  out        out  W      result
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  NaN        out  1      result is NaN (qualified by out_valid)
//  Exception  out  1      result is +/-Inf (overflow or Inf operand)
//  overflow   out  1      finite operands rounded past max exponent
//  zero       out  1      result is +/-0
//  inexact    out  1      nonzero guard/round/sticky bits discarded
// BEHAVIOUR
//  Reset (rst=0, async): all stage valids, out_valid, out and all flags = 0. Any in-flight data is discarded.
//  Pipeline: 3 registered stages, S1 align, S2 add/sub, S3 normalise/round/pack.
//  - Latency: 3 cycles from the accepting edge to out_valid, absent stalls.
//  - Throughput: 1 result per cycle.
//  Handshake:
//  - Transfer occurs when valid&&ready at the clock edge.
//  - Global advance = out_ready || !out_valid; in_ready = advance (combinational).
//  - When advance=0 all stages hold. out and flags stay stable while out_valid=1 && out_ready=0.
//  - Bubbles are not collapsed. Results leave in input order; nothing is dropped or duplicated.
//  S1 align:
//  - Unpack both operands. exp==0 is flushed to a signed zero (no subnormal support).
//  - Swap so A has |A| >= |B|, comparing {exp, frac}.
//  - d = expA - expB. Right-shift mantB into an (MAN_W+4)-bit field {1, frac, G, R, S}.
//  - Bits shifted out OR into S. For d >= MAN_W+3, mantB becomes sticky only.
//  S2 add/sub: add or subtract on MAN_W+5 bits including carry. Result sign = sign of larger magnitude.
//  S3 normalise/round/pack:
//  - Carry out: shift right 1, exp+1, shifted bit ORs into sticky.
//  - Otherwise left-normalise by leading-zero count and decrement exp. If exp would reach <= 0, flush to signed zero.
//  - Round to nearest even: increment when G && (R||S||lsb).
//  - Mantissa overflow from rounding: renormalise, exp+1.
//  - exp >= 2^EXP_W-1 after rounding gives Inf with the result sign; overflow=1, Exception=1, inexact=1.
//  Special cases (decided in S1 and carried down the pipeline):
//  - Any NaN operand, or Inf + (-Inf) after sub applied: out = canonical qNaN {0, all-1 exp, 1, 0...}, NaN=1.
//  - Single Inf operand, or same-sign Infs: out = that Inf, Exception=1.
//  - Exact cancellation x + (-x): out = +0. (-0) + (-0) = -0. zero=1.
//  Flags are registered alongside out and are meaningful only while out_valid=1.
// TESTING
//  1. 3F800000 + 3F800000 (sub=0) -> 40000000 at cycle 3 after accept; all flags 0.
//  2. 3F800000 - 3F800000 (sub=1) -> 00000000, zero=1. 80000000 + 80000000 -> 80000000, zero=1.
//  3. RNE tie: 3F800000 + 33800000 -> 3F800000, inexact=1. 3F800001 + 33800000 -> 3F800002, inexact=1.
//  4. Overflow/specials:
//     - 7F7FFFFF + 7F7FFFFF -> 7F800000, overflow=1, Exception=1.
//     - 7F800000 + FF800000 -> 7FC00000, NaN=1.
//  5. Backpressure: stream 6 operand pairs; hold out_ready=0 for 5 cycles mid-stream.
//     - in_ready drops. All 6 results emerge once each, in order.
//     - out is stable during the stall.
//  6. Reset mid-flight: assert rst low with 3 ops in flight.
//     - out_valid=0 immediately, no stale result after release.
//     - Rerun scenario 1 with EXP_W=5, MAN_W=10: 3C00+3C00 -> 4000.

Source files
------------

// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round/pack)
// with round-to-nearest-even, flush-to-zero and a single global stall.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EXP_W+MAN_W:0]   OperandA,
   input  logic [EXP_W+MAN_W:0]   OperandB,
   input  logic                   sub,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [EXP_W+MAN_W:0]   out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   NaN,
   output logic                   Exception,
   output logic                   overflow,
   output logic                   zero,
   output logic                   inexact
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int FW   = MAN_W + 4;
   localparam int LZ_W = $clog2(MAN_W + 5);
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic signed [EXP_W+1:0] EXP_MAX_S = signed'({2'b00, EXP_MAX});

   // Handshake: a transfer happens on a clock edge where valid && ready.
   // Every stage moves together when advance=1 and holds otherwise, so the
   // result registers stay stable while out_valid=1 and out_ready=0.
   logic advance;
   assign advance  = out_ready || !out_valid;
   assign in_ready = advance;

   function automatic logic [LZ_W-1:0] lzc(input logic [FW-1:0] v);
      lzc = '0;
      for (int i = 0; i < FW; i++) begin
         if (v[i]) lzc = LZ_W'(FW - 1 - i);
      end
   endfunction

   // ---------------- S1: unpack, classify, swap, align ----------------
   logic             sign_a, sign_b, nan_a, nan_b, inf_a, inf_b, a_ge;
   logic [EXP_W-1:0] exp_a, exp_b, big_exp, small_exp, d;
   logic [MAN_W-1:0] frac_a, frac_b, big_frac, small_frac;
   logic             big_sign, small_sign;
   logic [FW-1:0]    small_full, small_shift, small_lost;
   logic             c1_nan, c1_inf, c1_inf_sign;

   always_comb begin
      sign_a = OperandA[W-1];
      sign_b = OperandB[W-1] ^ sub;
      exp_a  = OperandA[W-2:MAN_W];
      exp_b  = OperandB[W-2:MAN_W];
      frac_a = OperandA[MAN_W-1:0];
      frac_b = OperandB[MAN_W-1:0];
      nan_a  = (exp_a == EXP_MAX) && (frac_a != '0);
      nan_b  = (exp_b == EXP_MAX) && (frac_b != '0);
      inf_a  = (exp_a == EXP_MAX) && (frac_a == '0);
      inf_b  = (exp_b == EXP_MAX) && (frac_b == '0);
      c1_nan      = nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b));
      c1_inf      = (inf_a || inf_b) && !c1_nan;
      c1_inf_sign = inf_a ? sign_a : sign_b;
      // No subnormals: a zero exponent means a (signed) zero.
      if (exp_a == '0) frac_a = '0;
      if (exp_b == '0) frac_b = '0;
      a_ge = {exp_a, frac_a} >= {exp_b, frac_b};
      if (a_ge) begin
         big_sign = sign_a; big_exp = exp_a; big_frac = frac_a;
         small_sign = sign_b; small_exp = exp_b; small_frac = frac_b;
      end else begin
         big_sign = sign_b; big_exp = exp_b; big_frac = frac_b;
         small_sign = sign_a; small_exp = exp_a; small_frac = frac_a;
      end
      d           = big_exp - small_exp;
      small_full  = {(small_exp != '0), small_frac, 3'b000};
      small_shift = small_full >> d;
      small_lost  = small_full & ~({FW{1'b1}} << d);
   end

   logic             s1_valid, s1_sign, s1_eff_sub, s1_nan, s1_inf, s1_inf_sign;
   logic [EXP_W-1:0] s1_exp;
   logic [FW-1:0]    s1_ma, s1_mb;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid    <= 1'b0;
         s1_sign     <= 1'b0;
         s1_eff_sub  <= 1'b0;
         s1_nan      <= 1'b0;
         s1_inf      <= 1'b0;
         s1_inf_sign <= 1'b0;
         s1_exp      <= '0;
         s1_ma       <= '0;
         s1_mb       <= '0;
      end else if (advance) begin
         s1_valid    <= in_valid;
         s1_sign     <= big_sign;
         s1_eff_sub  <= big_sign ^ small_sign;
         s1_nan      <= c1_nan;
         s1_inf      <= c1_inf;
         s1_inf_sign <= c1_inf_sign;
         s1_exp      <= big_exp;
         s1_ma       <= {(big_exp != '0), big_frac, 3'b000};
         s1_mb       <= {small_shift[FW-1:1], small_shift[0] | (|small_lost)};
      end
   end

   // ---------------- S2: magnitude add / subtract ----------------
   logic [FW:0] sum;
   always_comb begin
      if (s1_eff_sub) sum = {1'b0, s1_ma} - {1'b0, s1_mb};
      else            sum = {1'b0, s1_ma} + {1'b0, s1_mb};
   end

   logic             s2_valid, s2_sign, s2_eff_sub, s2_nan, s2_inf, s2_inf_sign;
   logic [EXP_W-1:0] s2_exp;
   logic [FW:0]      s2_sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid    <= 1'b0;
         s2_sign     <= 1'b0;
         s2_eff_sub  <= 1'b0;
         s2_nan      <= 1'b0;
         s2_inf      <= 1'b0;
         s2_inf_sign <= 1'b0;
         s2_exp      <= '0;
         s2_sum      <= '0;
      end else if (advance) begin
         s2_valid    <= s1_valid;
         s2_sign     <= s1_sign;
         s2_eff_sub  <= s1_eff_sub;
         s2_nan      <= s1_nan;
         s2_inf      <= s1_inf;
         s2_inf_sign <= s1_inf_sign;
         s2_exp      <= s1_exp;
         s2_sum      <= sum;
      end
   end

   // ---------------- S3: normalise, round, pack ----------------
   logic [FW-1:0]             norm;
   logic [LZ_W-1:0]           lz;
   logic signed [EXP_W+1:0]   e_base, e_norm, e_fin;
   logic                      inc;
   logic [MAN_W+1:0]          mant_r;
   logic [MAN_W-1:0]          frac_fin;
   logic [W-1:0]              res;
   logic                      r_nan, r_exc, r_ovf, r_zero, r_inx;

   always_comb begin
      e_base = signed'({2'b00, s2_exp});
      lz     = lzc(s2_sum[FW-1:0]);
      if (s2_sum[FW]) begin
         norm   = {s2_sum[FW:2], s2_sum[1] | s2_sum[0]};
         e_norm = e_base + (EXP_W+2)'(1);
      end else begin
         norm   = s2_sum[FW-1:0] << lz;
         e_norm = e_base - signed'({{(EXP_W+2-LZ_W){1'b0}}, lz});
      end
      inc    = norm[2] && (norm[1] || norm[0] || norm[3]);
      mant_r = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
      // Rounding can carry into a new leading bit (1.11..1 -> 10.00..0).
      if (mant_r[MAN_W+1]) begin
         e_fin    = e_norm + (EXP_W+2)'(1);
         frac_fin = mant_r[MAN_W:1];
      end else begin
         e_fin    = e_norm;
         frac_fin = mant_r[MAN_W-1:0];
      end
      res    = '0;
      r_nan  = 1'b0;
      r_exc  = 1'b0;
      r_ovf  = 1'b0;
      r_zero = 1'b0;
      r_inx  = 1'b0;
      if (s2_nan) begin
         res   = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
         r_nan = 1'b1;
      end else if (s2_inf) begin
         res   = {s2_inf_sign, EXP_MAX, {MAN_W{1'b0}}};
         r_exc = 1'b1;
      end else if (s2_sum == '0) begin
         // Exact cancellation gives +0; only (-0)+(-0) keeps the minus sign.
         res    = {s2_sign && !s2_eff_sub, {(W-1){1'b0}}};
         r_zero = 1'b1;
      end else if (!s2_sum[FW] && (e_norm[EXP_W+1] || e_norm == '0)) begin
         res    = {s2_sign, {(W-1){1'b0}}};
         r_zero = 1'b1;
         r_inx  = 1'b1;
      end else if (e_fin >= EXP_MAX_S) begin
         res   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
         r_exc = 1'b1;
         r_ovf = 1'b1;
         r_inx = 1'b1;
      end else begin
         res   = {s2_sign, e_fin[EXP_W-1:0], frac_fin};
         r_inx = |norm[2:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         NaN       <= 1'b0;
         Exception <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         inexact   <= 1'b0;
      end else if (advance) begin
         out_valid <= s2_valid;
         out       <= res;
         NaN       <= r_nan;
         Exception <= r_exc;
         overflow  <= r_ovf;
         zero      <= r_zero;
         inexact   <= r_inx;
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed vector table, exact-arithmetic reference model
// for random traffic, backpressure and mid-flight reset sequences, half precision.
module tb_fp_add_pipe;

   logic        clk, rst;
   logic [31:0] op_a, op_b, res;
   logic        sub, in_valid, in_ready, out_valid, out_ready;
   logic        nan_f, exc_f, ovf_f, zero_f, inx_f;

   logic [15:0] h_a, h_b, h_res;
   logic        h_sub, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
   logic        h_nan, h_exc, h_ovf, h_zero, h_inx;

   fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .OperandA(op_a), .OperandB(op_b), .sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .out(res), .out_valid(out_valid),
      .out_ready(out_ready), .NaN(nan_f), .Exception(exc_f), .overflow(ovf_f),
      .zero(zero_f), .inexact(inx_f)
   );

   fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .OperandA(h_a), .OperandB(h_b), .sub(h_sub),
      .in_valid(h_in_valid), .in_ready(h_in_ready), .out(h_res), .out_valid(h_out_valid),
      .out_ready(h_out_ready), .NaN(h_nan), .Exception(h_exc), .overflow(h_ovf),
      .zero(h_zero), .inexact(h_inx)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [36:0] exp_q[$];   // {NaN, Exception, overflow, zero, inexact, result}
   int n_out = 0;
   int stall_low = 0;
   logic rand_bp = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, req);
      end
   endtask

   initial begin : monitor
      logic        prev_stall;
      logic [36:0] prev_word, e;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_valid)
               chk("stall_hold", {nan_f, exc_f, ovf_f, zero_f, inx_f, res}, prev_word);
            if (out_valid && !out_ready) begin
               chk("in_ready_stall", in_ready, 0);
               stall_low++;
            end
            if (out_valid && out_ready) begin
               n_out++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual=%h expected=none", res);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", {nan_f, exc_f, ovf_f, zero_f, inx_f, res}, e);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {nan_f, exc_f, ovf_f, zero_f, inx_f, res};
         end
      end
   end

   initial begin : random_ready
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- reference model ----------------
   // Exact integer sum of the two aligned significands, then one RNE rounding.
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic         sa, sb, sr, na, nb, ia, ib, inc, inx;
      int           ea, eb, e0, p, e, sh;
      logic [127:0] ma, mb, va, vb, mag, kept, rem, half;
      sa = a[31];
      sb = b[31] ^ s;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      if (na || nb || (ia && ib && sa != sb)) return {5'b10000, 32'h7FC00000};
      if (ia) return {5'b01000, sa, 8'hFF, 23'h0};
      if (ib) return {5'b01000, sb, 8'hFF, 23'h0};
      ma = (ea == 0) ? 128'd0 : {104'd1, a[22:0]};
      mb = (eb == 0) ? 128'd0 : {104'd1, b[22:0]};
      if (ea == 0) ea = eb;
      if (eb == 0) eb = ea;
      e0 = (ea < eb) ? ea : eb;
      va = ma << (ea - e0);
      vb = mb << (eb - e0);
      if (sa == sb) begin mag = va + vb; sr = sa; end
      else if (va >= vb) begin mag = va - vb; sr = sa; end
      else begin mag = vb - va; sr = sb; end
      if (mag == 0) return {5'b00010, (sa == sb) && sa, 31'h0};
      p = 0;
      for (int i = 0; i < 128; i++) if (mag[i]) p = i;
      e = e0 + p - 23;
      if (p > 23) begin
         sh   = p - 23;
         kept = mag >> sh;
         rem  = mag & ((128'd1 << sh) - 128'd1);
         half = 128'd1 << (sh - 1);
         inc  = (rem > half) || (rem == half && kept[0]);
         inx  = (rem != 0);
      end else begin
         kept = mag << (23 - p);
         inc  = 1'b0;
         inx  = 1'b0;
      end
      kept = kept + {127'd0, inc};
      if (kept[24]) begin kept = kept >> 1; e++; end
      if (e >= 255) return {5'b01101, sr, 8'hFF, 23'h0};
      if (e <= 0) return {5'b00011, sr, 31'h0};
      return {4'b0000, inx, sr, 8'(e), kept[22:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [36:0] e);
      logic acc;
      acc = 1'b0;
      op_a = a; op_b = b; sub = s; in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) exp_q.push_back(e);
         @(posedge clk);
         #1;
         if (acc) break;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted expected=accepted");
      end
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
      @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic gen(output logic [31:0] a, output logic [31:0] b, output logic s);
      int ea, eb, mode;
      logic [22:0] fa, fb;
      ea = $urandom_range(70, 200);
      eb = ea + $urandom_range(0, 80) - 40;
      fa = 23'($urandom());
      fb = 23'($urandom());
      mode = $urandom_range(0, 15);
      if (mode < 4) begin eb = ea; fb = fa ^ 23'($urandom_range(0, 255)); end
      else if (mode == 4) eb = 0;
      else if (mode == 5) begin ea = 255; if ($urandom_range(0, 1) == 1) fa = '0; end
      a = {1'($urandom_range(0, 1)), 8'(ea), fa};
      b = {1'($urandom_range(0, 1)), 8'(eb), fb};
      s = 1'($urandom_range(0, 1));
   endtask

   // ---------------- test ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [4:0]  fl;   // {NaN, Exception, overflow, zero, inexact}
      logic [31:0] r;
   } vec_t;

   vec_t vecs[21];

   initial begin : main
      logic [31:0] ra, rb;
      logic        rs;
      logic [15:0] ha[3], hb[3], hr[3];
      logic        hs[3];
      logic [4:0]  hf[3];
      int          lat, base;

      vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 5'b00000, 32'h40000000};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 5'b00010, 32'h00000000};
      vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 5'b00010, 32'h80000000};
      vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 5'b00001, 32'h3F800000};
      vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 5'b00001, 32'h3F800002};
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'b01101, 32'h7F800000};
      vecs[6]  = '{32'h7F800000, 32'hFF800000, 1'b0, 5'b10000, 32'h7FC00000};
      vecs[7]  = '{32'h7F800000, 32'h3F800000, 1'b0, 5'b01000, 32'h7F800000};
      vecs[8]  = '{32'hFF800000, 32'h7F800000, 1'b1, 5'b01000, 32'hFF800000};
      vecs[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 5'b10000, 32'h7FC00000};
      vecs[10] = '{32'h7F800000, 32'h7F800000, 1'b1, 5'b10000, 32'h7FC00000};
      vecs[11] = '{32'h40400000, 32'h3F800000, 1'b1, 5'b00000, 32'h40000000};
      vecs[12] = '{32'h3F800000, 32'hBF800000, 1'b0, 5'b00010, 32'h00000000};
      vecs[13] = '{32'h00000000, 32'h80000000, 1'b0, 5'b00010, 32'h00000000};
      vecs[14] = '{32'h00400000, 32'h3F800000, 1'b0, 5'b00000, 32'h3F800000};
      vecs[15] = '{32'h40000000, 32'hC0400000, 1'b0, 5'b00000, 32'hBF800000};
      vecs[16] = '{32'h3F800000, 32'h3F000000, 1'b0, 5'b00000, 32'h3FC00000};
      vecs[17] = '{32'h4B7FFFFF, 32'h3F800000, 1'b0, 5'b00000, 32'h4B800000};
      vecs[18] = '{32'h3F800000, 32'h33800000, 1'b1, 5'b00000, 32'h3F7FFFFF};
      vecs[19] = '{32'h3F800000, 32'h33000000, 1'b1, 5'b00001, 32'h3F800000};
      vecs[20] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 5'b01101, 32'h7F800000};

      ha[0] = 16'h3C00; hb[0] = 16'h3C00; hs[0] = 1'b0; hf[0] = 5'b00000; hr[0] = 16'h4000;
      ha[1] = 16'h3C00; hb[1] = 16'h3C00; hs[1] = 1'b1; hf[1] = 5'b00010; hr[1] = 16'h0000;
      ha[2] = 16'h7BFF; hb[2] = 16'h7BFF; hs[2] = 1'b0; hf[2] = 5'b01101; hr[2] = 16'h7C00;

      rst = 1'b0;
      op_a = '0; op_b = '0; sub = 1'b0; in_valid = 1'b0;
      h_a = '0; h_b = '0; h_sub = 1'b0; h_in_valid = 1'b0; h_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out", res, 0);
      chk("reset_flags", {nan_f, exc_f, ovf_f, zero_f, inx_f}, 0);
      chk("reset_h_out_valid", h_out_valid, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single op: latency counted in edges, accepting edge included.
      op_a = vecs[0].a; op_b = vecs[0].b; sub = vecs[0].s; in_valid = 1'b1;
      exp_q.push_back({vecs[0].fl, vecs[0].r});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, 3);
      wait_drain();

      for (int i = 0; i < 21; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].fl, vecs[i].r});
         wait_drain();
      end

      // Back-to-back streaming of the whole table.
      for (int i = 0; i < 21; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].fl, vecs[i].r});
      wait_drain();

      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         gen(ra, rb, rs);
         send(ra, rb, rs, model(ra, rb, rs));
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_drain();

      // Six ops with a 5-cycle consumer stall mid-stream.
      base = n_out;
      stall_low = 0;
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 6; i++) begin
         gen(ra, rb, rs);
         send(ra, rb, rs, model(ra, rb, rs));
      end
      wait_drain();
      chk("bp_count", n_out - base, 6);
      chk("bp_stall_cycles", stall_low, 5);

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) begin
         gen(ra, rb, rs);
         send(ra, rb, rs, model(ra, rb, rs));
      end
      #2;
      rst = 1'b0;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_out", res, 0);
      chk("midreset_flags", {nan_f, exc_f, ovf_f, zero_f, inx_f}, 0);
      exp_q.delete();
      base = n_out;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("no_stale_after_reset", n_out - base, 0);
      send(vecs[0].a, vecs[0].b, vecs[0].s, {vecs[0].fl, vecs[0].r});
      wait_drain();

      // Half-precision instance.
      for (int i = 0; i < 3; i++) begin
         h_a = ha[i]; h_b = hb[i]; h_sub = hs[i]; h_in_valid = 1'b1;
         @(posedge clk);
         #1;
         h_in_valid = 1'b0;
         lat = 1;
         while (!h_out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
         end
         chk("h_latency", lat, 3);
         chk("h_result", {h_nan, h_exc, h_ovf, h_zero, h_inx, h_res}, {hf[i], hr[i]});
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
